riscv_run_ctrl: RTL and testbench

Synthesizable run controller for the verilog_riscv core, replacing ad-hoc simulation reset/counter/finish logic. It sequences core reset and drives the free-running cycle counter into the core's i_counter. It gates core execution through run, pause and single-step modes, and terminates a run on core halt, external stop or cycle limit. After a stop request it holds the core enabled for a drain window, then reports a latched completion status.

---
 rtl/riscv_run_ctrl_pkg.sv | 26 ++
 rtl/run_ctrl_dncnt.sv | 30 +++
 rtl/riscv_run_ctrl.sv | 169 ++++++++++++++++
 tb/tb_riscv_run_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_run_ctrl_pkg.sv
// Shared encodings for the run controller: FSM states, completion status codes
// and the sizing helper for the reusable window down-counter.
package riscv_run_ctrl_pkg;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } run_state_e;

  typedef enum logic [1:0] {
    STAT_NONE    = 2'd0,
    STAT_HALT    = 2'd1,
    STAT_STOP    = 2'd2,
    STAT_TIMEOUT = 2'd3
  } run_status_e;

  // The counter is loaded with (window - 1), so clog2 of the larger window suffices.
  function automatic int dncnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/run_ctrl_dncnt.sv
// Loadable down-counter with a zero flag; it times both the reset-hold
// window and the post-stop drain window of the run controller.
module run_ctrl_dncnt #(
  parameter int           W       = 2,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Load wins over decrement; the count parks at zero rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= RST_VAL;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/riscv_run_ctrl.sv
// Run controller for the verilog_riscv core: sequences core reset, gates execution
// (run/pause/step), ends the run on halt/stop/timeout and reports a sticky status.
module riscv_run_ctrl
  import riscv_run_ctrl_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int RST_CYCLES   = 1,
  parameter int MAX_CYCLES   = 10000,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_halt,
  input  logic             i_stop,
  input  logic             i_pause,
  input  logic             i_step,
  output logic             o_core_rst,
  output logic             o_run,
  output logic [CNT_W-1:0] o_counter,
  output logic             o_done,
  output logic [1:0]       o_status,
  output logic [CNT_W-1:0] o_halt_cycle
);

  localparam int              DW         = dncnt_width(RST_CYCLES, DRAIN_CYCLES);
  localparam logic [DW-1:0]   HOLD_LOAD  = DW'(RST_CYCLES - 1);
  localparam logic [DW-1:0]   DRAIN_LOAD = (DRAIN_CYCLES > 0) ? DW'(DRAIN_CYCLES - 1) : DW'(0);
  localparam logic [CNT_W-1:0] MAX_V     = CNT_W'(MAX_CYCLES);
  localparam bit              TIMEOUT_EN = (MAX_CYCLES != 0);

  generate
    if (RST_CYCLES < 1) begin : g_bad_rst_cycles
      $error("riscv_run_ctrl: RST_CYCLES must be at least 1");
    end
    if (DRAIN_CYCLES < 0) begin : g_bad_drain_cycles
      $error("riscv_run_ctrl: DRAIN_CYCLES must not be negative");
    end
    if ((64'(MAX_CYCLES) >> CNT_W) != 64'd0) begin : g_bad_max_cycles
      $error("riscv_run_ctrl: MAX_CYCLES must be below 2**CNT_W");
    end
  endgenerate

  run_state_e       state, state_nxt;
  run_status_e      cause;
  logic             core_rst_nxt;
  logic             run_nxt;
  logic             done_nxt;
  logic [1:0]       status_nxt;
  logic [CNT_W-1:0] counter_nxt;
  logic [CNT_W-1:0] halt_cycle_nxt;
  logic             dn_load;
  logic             dn_en;
  logic             dn_zero;

  run_ctrl_dncnt #(
    .W       (DW),
    .RST_VAL (HOLD_LOAD)
  ) u_dncnt (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .load     (dn_load),
    .en       (dn_en),
    .load_val (DRAIN_LOAD),
    .zero     (dn_zero)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= HOLD;
    end else begin
      state <= state_nxt;
    end
  end

  // Every output is a register, so the comb block computes their next values.
  always_comb begin
    state_nxt      = state;
    core_rst_nxt   = o_core_rst;
    run_nxt        = o_run;
    done_nxt       = o_done;
    status_nxt     = o_status;
    counter_nxt    = o_counter;
    halt_cycle_nxt = o_halt_cycle;
    dn_load        = 1'b0;
    dn_en          = 1'b0;
    cause          = STAT_NONE;

    unique case (state)
      HOLD: begin
        counter_nxt = o_counter + CNT_W'(1);
        if (dn_zero) begin
          state_nxt    = RUN;
          core_rst_nxt = 1'b0;
          run_nxt      = 1'b1;
        end else begin
          dn_en = 1'b1;
        end
      end

      RUN: begin
        if (o_run) begin
          counter_nxt = o_counter + CNT_W'(1);
        end
        run_nxt = ~i_pause | i_step;

        // Halt and stop are honoured even while paused; timeout only on an enabled cycle.
        if (i_halt) begin
          cause = STAT_HALT;
        end else if (i_stop) begin
          cause = STAT_STOP;
        end else if (TIMEOUT_EN && o_run && (o_counter == MAX_V)) begin
          cause = STAT_TIMEOUT;
        end

        if (cause != STAT_NONE) begin
          status_nxt     = cause;
          halt_cycle_nxt = o_counter;
          dn_load        = 1'b1;
          if (DRAIN_CYCLES == 0) begin
            state_nxt = DONE;
            run_nxt   = 1'b0;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = DRAIN;
            run_nxt   = 1'b1;
          end
        end
      end

      DRAIN: begin
        counter_nxt = o_counter + CNT_W'(1);
        if (dn_zero) begin
          state_nxt = DONE;
          run_nxt   = 1'b0;
          done_nxt  = 1'b1;
        end else begin
          dn_en = 1'b1;
        end
      end

      DONE: begin
        run_nxt = 1'b0;
      end

      default: begin
        state_nxt = HOLD;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_core_rst   <= 1'b1;
      o_run        <= 1'b0;
      o_counter    <= CNT_W'(1);
      o_done       <= 1'b0;
      o_status     <= STAT_NONE;
      o_halt_cycle <= '0;
    end else begin
      o_core_rst   <= core_rst_nxt;
      o_run        <= run_nxt;
      o_counter    <= counter_nxt;
      o_done       <= done_nxt;
      o_status     <= status_nxt;
      o_halt_cycle <= halt_cycle_nxt;
    end
  end

endmodule

// File: tb/tb_riscv_run_ctrl.sv
// Self-checking bench for riscv_run_ctrl: three parameterisations share one clock and
// one set of stimulus inputs; the selected instance is checked against a cycle model.
module tb_riscv_run_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic halt, stop, pause, step;
  logic rstA, rstB, rstC;

  logic        aCoreRst, aRun, aDone;
  logic [31:0] aCounter, aHaltCycle;
  logic [1:0]  aStatus;
  logic        bCoreRst, bRun, bDone;
  logic [7:0]  bCounter, bHaltCycle;
  logic [1:0]  bStatus;
  logic        cCoreRst, cRun, cDone;
  logic [3:0]  cCounter, cHaltCycle;
  logic [1:0]  cStatus;

  riscv_run_ctrl #(.CNT_W(32), .RST_CYCLES(1), .MAX_CYCLES(10000), .DRAIN_CYCLES(4)) dutA (
    .i_clk(clk), .i_rst_n(rstA), .i_halt(halt), .i_stop(stop), .i_pause(pause), .i_step(step),
    .o_core_rst(aCoreRst), .o_run(aRun), .o_counter(aCounter), .o_done(aDone),
    .o_status(aStatus), .o_halt_cycle(aHaltCycle));

  riscv_run_ctrl #(.CNT_W(8), .RST_CYCLES(3), .MAX_CYCLES(40), .DRAIN_CYCLES(2)) dutB (
    .i_clk(clk), .i_rst_n(rstB), .i_halt(halt), .i_stop(stop), .i_pause(pause), .i_step(step),
    .o_core_rst(bCoreRst), .o_run(bRun), .o_counter(bCounter), .o_done(bDone),
    .o_status(bStatus), .o_halt_cycle(bHaltCycle));

  riscv_run_ctrl #(.CNT_W(4), .RST_CYCLES(1), .MAX_CYCLES(0), .DRAIN_CYCLES(0)) dutC (
    .i_clk(clk), .i_rst_n(rstC), .i_halt(halt), .i_stop(stop), .i_pause(pause), .i_step(step),
    .o_core_rst(cCoreRst), .o_run(cRun), .o_counter(cCounter), .o_done(cDone),
    .o_status(cStatus), .o_halt_cycle(cHaltCycle));

  int sel = 0;
  logic       curRst, curCoreRst, curRun, curDone;
  logic [1:0] curStatus;
  longint     curCounter, curHaltCycle;

  always_comb begin
    curRst = rstA; curCoreRst = aCoreRst; curRun = aRun; curDone = aDone;
    curStatus = aStatus; curCounter = 64'(aCounter); curHaltCycle = 64'(aHaltCycle);
    if (sel == 1) begin
      curRst = rstB; curCoreRst = bCoreRst; curRun = bRun; curDone = bDone;
      curStatus = bStatus; curCounter = 64'(bCounter); curHaltCycle = 64'(bHaltCycle);
    end else if (sel == 2) begin
      curRst = rstC; curCoreRst = cCoreRst; curRun = cRun; curDone = cDone;
      curStatus = cStatus; curCounter = 64'(cCounter); curHaltCycle = 64'(cHaltCycle);
    end
  end

  int compared = 0;
  int mismatched = 0;

  // Behavioural model of the selected instance: phases tracked as remaining-cycle budgets.
  int     pCntW, pRst, pMax, pDrain;
  longint mCnt, mHaltCycle;
  bit     mCoreRst, mRun, mDone, mDraining;
  int     mStatus, mHoldLeft, mDrainLeft;

  typedef struct {
    logic   halt;
    logic   stop;
    logic   pause;
    logic   step;
    logic   expRun;
    longint expCnt;
    int     expStatus;
    logic   expDone;
  } vec_t;

  vec_t pauseTbl[$];
  vec_t haltTbl[$];

  task automatic cmp(input string name, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mCnt = 1; mHaltCycle = 0; mCoreRst = 1; mRun = 0; mDone = 0; mDraining = 0;
    mStatus = 0; mHoldLeft = pRst; mDrainLeft = 0;
  endtask

  task automatic modelStep();
    longint mask = (64'd1 << pCntW) - 1;
    longint old;
    int cause;
    if (!curRst) begin
      modelReset();
      return;
    end
    if (mDone) return;
    if (mCoreRst) begin
      mCnt = (mCnt + 1) & mask;
      mHoldLeft--;
      if (mHoldLeft == 0) begin mCoreRst = 0; mRun = 1; end
      return;
    end
    if (mDraining) begin
      mCnt = (mCnt + 1) & mask;
      mDrainLeft--;
      if (mDrainLeft == 0) begin mDraining = 0; mDone = 1; mRun = 0; end
      return;
    end
    old = mCnt;
    cause = 0;
    if (halt) cause = 1;
    else if (stop) cause = 2;
    else if (pMax != 0 && mRun && mCnt == pMax) cause = 3;
    if (mRun) mCnt = (mCnt + 1) & mask;
    if (cause != 0) begin
      mStatus = cause;
      mHaltCycle = old;
      if (pDrain == 0) begin mDone = 1; mRun = 0; end
      else begin mDraining = 1; mDrainLeft = pDrain; mRun = 1; end
    end else begin
      mRun = !pause || step;
    end
  endtask

  task automatic checkOutput(input string tag);
    cmp({tag, ".core_rst"}, curCoreRst, mCoreRst);
    cmp({tag, ".run"}, curRun, mRun);
    cmp({tag, ".counter"}, curCounter, mCnt);
    cmp({tag, ".done"}, curDone, mDone);
    cmp({tag, ".status"}, curStatus, mStatus);
    cmp({tag, ".halt_cycle"}, curHaltCycle, mHaltCycle);
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkOutput("cycle");
  endtask

  task automatic applyStimulus(input logic h, input logic s, input logic p, input logic st);
    halt = h; stop = s; pause = p; step = st;
    tick();
  endtask

  task automatic applyRow(input vec_t v, input string name);
    applyStimulus(v.halt, v.stop, v.pause, v.step);
    cmp({name, ".run"}, curRun, v.expRun);
    cmp({name, ".counter"}, curCounter, v.expCnt);
    cmp({name, ".status"}, curStatus, v.expStatus);
    cmp({name, ".done"}, curDone, v.expDone);
  endtask

  task automatic setRst(input logic v);
    case (sel)
      0: rstA = v;
      1: rstB = v;
      default: rstC = v;
    endcase
  endtask

  task automatic selectDut(input int n, input int w, input int r, input int mx, input int dr);
    rstA = 0; rstB = 0; rstC = 0;
    sel = n; pCntW = w; pRst = r; pMax = mx; pDrain = dr;
    #1;
    modelReset();
  endtask

  task automatic releaseAndCount(input logic holdHalt, input string name);
    int n = 0;
    setRst(1'b1);
    halt = holdHalt; stop = 0; pause = 0; step = 0;
    while (curCoreRst === 1'b1 && n < 20) begin
      tick();
      n++;
    end
    halt = 0;
    cmp(name, n, pRst);
  endtask

  task automatic startDut(input logic holdHalt, input string name);
    setRst(1'b0);
    halt = 0; stop = 0; pause = 0; step = 0;
    tick();
    tick();
    releaseAndCount(holdHalt, name);
  endtask

  task automatic waitCounter(input longint target, input int budget, input string name);
    int n = 0;
    while (curCounter != target && n < budget) begin
      tick();
      n++;
    end
    cmp(name, curCounter, target);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: time limit reached before the test sequence completed");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int cycles;
    bit sawWrap;
    longint prev;
    logic pauseLvl;

    halt = 0; stop = 0; pause = 0; step = 0;
    rstA = 0; rstB = 0; rstC = 0;

    for (int i = 0; i < 10; i++) pauseTbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'd50, 0, 1'b0});
    pauseTbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 64'd50, 0, 1'b0});
    pauseTbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'd51, 0, 1'b0});
    pauseTbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 64'd51, 0, 1'b0});
    pauseTbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'd52, 0, 1'b0});
    pauseTbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 64'd52, 0, 1'b0});
    pauseTbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'd53, 0, 1'b0});
    pauseTbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'd53, 0, 1'b0});
    pauseTbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'd54, 0, 1'b0});

    haltTbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'd201, 1, 1'b0});
    haltTbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'd202, 1, 1'b0});
    haltTbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'd203, 1, 1'b0});
    haltTbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'd204, 1, 1'b0});
    haltTbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd205, 1, 1'b1});
    haltTbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'd205, 1, 1'b1});
    haltTbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd205, 1, 1'b1});

    // Instance A, first run: pause/step window at 50, then a halt at 200.
    selectDut(0, 32, 1, 10000, 4);
    @(negedge clk);
    cmp("A.reset.counter", curCounter, 1);
    cmp("A.reset.core_rst", curCoreRst, 1);
    startDut(1'b0, "A.rstCycles");
    waitCounter(49, 100, "A.reach49");
    foreach (pauseTbl[i]) applyRow(pauseTbl[i], $sformatf("pause[%0d]", i));
    waitCounter(200, 400, "A.reach200");
    foreach (haltTbl[i]) applyRow(haltTbl[i], $sformatf("halt[%0d]", i));
    cmp("A.halt.halt_cycle", curHaltCycle, 200);

    // Instance A, second run: timeout at MAX_CYCLES followed by the drain window.
    startDut(1'b0, "A.rstCycles2");
    waitCounter(10000, 10100, "A.reachMax");
    applyStimulus(0, 0, 0, 0);
    cmp("A.timeout.status", curStatus, 3);
    cmp("A.timeout.halt_cycle", curHaltCycle, 10000);
    n = 1;
    while (curRun === 1'b1 && n < 10) begin
      applyStimulus(0, 0, 1, 0);
      if (curRun === 1'b1) n++;
    end
    cmp("A.timeout.drainCycles", n, 4);
    cmp("A.timeout.done", curDone, 1);
    cmp("A.timeout.final", curCounter, 10005);
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 1);
    cmp("A.timeout.frozen", curCounter, 10005);
    cmp("A.timeout.sticky", curStatus, 3);

    // Instance A, third run: halt, stop and timeout all in one cycle.
    startDut(1'b1, "A.rstCycles3");
    waitCounter(10000, 10100, "A.reachMax2");
    applyStimulus(1, 1, 0, 0);
    cmp("A.tie.status", curStatus, 1);
    cmp("A.tie.halt_cycle", curHaltCycle, 10000);

    // Instance B: randomized rounds checked cycle by cycle against the model.
    selectDut(1, 8, 3, 40, 2);
    for (int r = 0; r < 8; r++) begin
      startDut(logic'(r[0]), $sformatf("B.rstCycles[%0d]", r));
      pauseLvl = 0;
      for (int c = 0; c < 60; c++) begin
        if ($urandom_range(0, 7) == 0) pauseLvl = ~pauseLvl;
        applyStimulus($urandom_range(0, 39) == 0, $urandom_range(0, 39) == 0,
                      pauseLvl, $urandom_range(0, 3) == 0);
      end
    end

    // Instance B: asynchronous reset in the middle of the drain window.
    startDut(1'b0, "B.rstCycles.pre");
    waitCounter(10, 50, "B.reach10");
    applyStimulus(0, 1, 0, 0);
    cmp("B.drain.status", curStatus, 2);
    cmp("B.drain.run", curRun, 1);
    setRst(1'b0);
    #1;
    modelReset();
    cmp("B.async.counter", curCounter, 1);
    cmp("B.async.core_rst", curCoreRst, 1);
    cmp("B.async.run", curRun, 0);
    cmp("B.async.status", curStatus, 0);
    cmp("B.async.halt_cycle", curHaltCycle, 0);
    cmp("B.async.done", curDone, 0);
    tick();
    tick();
    releaseAndCount(1'b0, "B.rstCycles.post");

    // Instance C: free-running 4-bit counter wraps without timeout; zero drain stops at once.
    selectDut(2, 4, 1, 0, 0);
    startDut(1'b0, "C.rstCycles");
    sawWrap = 0;
    prev = curCounter;
    cycles = 0;
    while (cycles < 40) begin
      applyStimulus(0, 0, 0, 0);
      if (prev == 15 && curCounter == 0) sawWrap = 1;
      prev = curCounter;
      cycles++;
    end
    cmp("C.wrap", sawWrap, 1);
    cmp("C.notDone", curDone, 0);
    prev = curCounter;
    applyStimulus(0, 1, 0, 0);
    cmp("C.stop.done", curDone, 1);
    cmp("C.stop.run", curRun, 0);
    cmp("C.stop.status", curStatus, 2);
    cmp("C.stop.halt_cycle", curHaltCycle, prev);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
